imm_extend_stage: RTL and testbench
===================================

// Module: imm_extend_stage
// PURPOSE
//  Registered immediate generator for the decode stage: extracts and extends the
//  immediate from a 32-bit instruction per format select, with valid/ready on both
//  sides and a 2-entry skid buffer so decode back-pressure never drops an instruction.
//  Generalises the combinational extender to any XLEN, adds J/Z/64-bit shamt formats,
//  a sideband tag (rd/PC index) and a pipeline flush.
// PARAMETERS
//  DATA_WIDTH  32  immediate width (XLEN); legal values 32 or 64
//  TAG_WIDTH   5   sideband tag carried alongside the immediate, unmodified
// PORTS
//  clk        in   1           clock, rising edge
//  rst        in   1           asynchronous reset, active-high
//  flush      in   1           synchronous flush: discard all buffered entries
//  in_valid   in   1           instr/ImmSrc/in_tag valid
//  in_ready   out  1           stage can accept this cycle
//  instr      in   32          raw instruction
//  ImmSrc     in   3           format select (see BEHAVIOUR)
//  in_tag     in   TAG_WIDTH   sideband tag
//  out_valid  out  1           out_imm/out_tag valid
//  out_ready  in   1           consumer accepts this cycle
//  out_imm    out  DATA_WIDTH  extended immediate
//  out_tag    out  TAG_WIDTH   tag of the entry in out_imm
// BEHAVIOUR
//  Formats (sign bit = instr[31], S = sign-fill to DATA_WIDTH):
//   0 I : S, instr[31:20]                1 S : S, instr[31:25], instr[11:7]
//   2 B : S, instr[7],[30:25],[11:8],0   3 U : S, instr[31:12], 12'b0
//   4 I5: zero-ext instr[24:20] (DATA_WIDTH=32) / instr[25:20] (DATA_WIDTH=64)
//   5 J : S, instr[19:12],[20],[30:21],0 6 Z : zero-ext instr[19:15] (CSR zimm)
//   7   : reserved -> immediate 0
//  U at DATA_WIDTH=64 sign-extends bit 31 into [63:32].
//  Storage: main reg (drives outputs) + skid reg. States EMPTY, ONE, FULL.
//  Accept = in_valid & in_ready; drain = out_valid & out_ready.
//   EMPTY: accept -> ONE (load main).
//   ONE  : accept&drain -> ONE (main reloaded); drain only -> EMPTY;
//          accept only -> FULL (load skid); neither -> ONE.
//   FULL : drain -> ONE (main <= skid); no accept possible.
//  in_ready = (state != FULL), registered, never depends combinationally on out_ready.
//  out_valid = (state != EMPTY). Latency: accept in cycle N -> out_valid in N+1.
//  Order strictly FIFO; out_imm/out_tag held stable while out_valid & !out_ready.
//  flush: next state EMPTY; any same-cycle accept is discarded; flush overrides all.
//  Reset (async, mid-operation included): state EMPTY, out_valid=0, out_imm=0,
//  out_tag=0, skid contents 0, in_ready=1 from first clock edge after deassert.
//  Data regs update only on load; no X propagation from unused ImmSrc/instr bits.
// CONFIGURATION
//  IMM_ILLEGAL_EN defined: adds port out_illegal (out, 1), buffered with the entry;
//   1 when ImmSrc==7, or ImmSrc==4 with DATA_WIDTH=32 and instr[25]==1; reset 0.
//  IMM_ILLEGAL_EN undefined: port absent; ImmSrc 7 yields 0 silently, I5 ignores
//   instr[25] at DATA_WIDTH=32.
// TESTING
//  T1 I-type instr=32'hFFF00093, ImmSrc=0, out_ready=1 -> next cycle out_imm=32'hFFFFFFFF.
//  T2 J-type instr=32'h8000006F, ImmSrc=5, DATA_WIDTH=64 -> out_imm=64'hFFFFFFFFFFF00000.
//  T3 out_ready=0, push tags 1,2 -> in_ready=0 after 2nd accept; release -> tags 1,2 in order, no loss.
//  T4 FULL state, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, input dropped.
//  T5 rst pulsed mid-stream while FULL -> out_valid=0, out_imm=0, out_tag=0 immediately.
//  T6 IMM_ILLEGAL_EN: ImmSrc=7 -> out_imm=0, out_illegal=1; ImmSrc=6 instr[19:15]=5'h1F -> imm=31, illegal=0.

Source files
------------

// File: rtl/imm_extend_stage.sv
// Registered immediate extender for decode with a 2-entry skid buffer; 1-cycle latency; in_ready is registered (low only when both entries are held).
// Optional `IMM_ILLEGAL_EN adds out_illegal, flagging reserved/illegal immediate formats alongside each entry.
module imm_extend_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instr,
    input  logic [2:0]            ImmSrc,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_imm,
    output logic [TAG_WIDTH-1:0]  out_tag
`ifdef IMM_ILLEGAL_EN
    ,
    output logic                  out_illegal
`endif
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t state, state_nxt;

    logic [31:0]           imm32;
    logic                  sext;
    logic [DATA_WIDTH-1:0] imm_c;
    logic                  accept, drain;
    logic                  load_main_in, load_main_skid, load_skid;
    logic [DATA_WIDTH-1:0] skid_imm;
    logic [TAG_WIDTH-1:0]  skid_tag;
    logic                  unused_opcode;

    assign unused_opcode = ^instr[6:0];

    // Formats are built in 32 bits, then widened by sign-fill or zero-fill.
    always_comb begin
        imm32 = '0;
        sext  = 1'b0;
        case (ImmSrc)
            3'd0: begin imm32 = {{20{instr[31]}}, instr[31:20]};                           sext = 1'b1; end
            3'd1: begin imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};              sext = 1'b1; end
            3'd2: begin imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}; sext = 1'b1; end
            3'd3: begin imm32 = {instr[31:12], 12'b0};                                     sext = 1'b1; end
            3'd4: begin
                if (DATA_WIDTH == 64) imm32 = {26'b0, instr[25:20]};
                else                  imm32 = {27'b0, instr[24:20]};
            end
            3'd5: begin imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}; sext = 1'b1; end
            3'd6: imm32 = {27'b0, instr[19:15]};
            default: imm32 = '0;
        endcase
        imm_c       = sext ? {DATA_WIDTH{imm32[31]}} : '0;
        imm_c[31:0] = imm32;
    end

    assign accept = in_valid & in_ready & ~flush;
    assign drain  = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: if (accept) state_nxt = ONE;
                ONE: begin
                    if (accept && !drain)      state_nxt = FULL;
                    else if (!accept && drain) state_nxt = EMPTY;
                end
                FULL:    if (drain) state_nxt = ONE;
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_comb begin
        in_ready       = (state != FULL);
        out_valid      = (state != EMPTY);
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (!flush) begin
            case (state)
                EMPTY: load_main_in = accept;
                ONE: begin
                    load_main_in = accept & drain;
                    load_skid    = accept & ~drain;
                end
                FULL:    load_main_skid = drain;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_imm  <= '0;
            out_tag  <= '0;
            skid_imm <= '0;
            skid_tag <= '0;
        end else begin
            if (load_main_in) begin
                out_imm <= imm_c;
                out_tag <= in_tag;
            end else if (load_main_skid) begin
                out_imm <= skid_imm;
                out_tag <= skid_tag;
            end
            if (load_skid) begin
                skid_imm <= imm_c;
                skid_tag <= in_tag;
            end
        end
    end

`ifdef IMM_ILLEGAL_EN
    logic ill_c, skid_ill;

    assign ill_c = (ImmSrc == 3'd7) || ((ImmSrc == 3'd4) && (DATA_WIDTH == 32) && instr[25]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_illegal <= 1'b0;
            skid_ill    <= 1'b0;
        end else begin
            if (load_main_in)        out_illegal <= ill_c;
            else if (load_main_skid) out_illegal <= skid_ill;
            if (load_skid)           skid_ill    <= ill_c;
        end
    end
`endif

endmodule

// File: tb/tb_imm_extend_stage.sv
// Bench for imm_extend_stage: 32- and 64-bit instances side by side against a queue-based reference.
module tb_imm_extend_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] instr;
    logic [2:0]  ImmSrc;
    logic [4:0]  in_tag;

    logic        in_ready32, out_valid32, ill32;
    logic [31:0] out_imm32;
    logic [4:0]  out_tag32;
    logic        in_ready64, out_valid64, ill64;
    logic [63:0] out_imm64;
    logic [4:0]  out_tag64;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    imm_extend_stage #(.DATA_WIDTH(32), .TAG_WIDTH(5)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
        .instr(instr), .ImmSrc(ImmSrc), .in_tag(in_tag), .out_valid(out_valid32),
        .out_ready(out_ready), .out_imm(out_imm32), .out_tag(out_tag32)
`ifdef IMM_ILLEGAL_EN
        , .out_illegal(ill32)
`endif
    );

    imm_extend_stage #(.DATA_WIDTH(64), .TAG_WIDTH(5)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .instr(instr), .ImmSrc(ImmSrc), .in_tag(in_tag), .out_valid(out_valid64),
        .out_ready(out_ready), .out_imm(out_imm64), .out_tag(out_tag64)
`ifdef IMM_ILLEGAL_EN
        , .out_illegal(ill64)
`endif
    );

`ifndef IMM_ILLEGAL_EN
    assign ill32 = 1'b0;
    assign ill64 = 1'b0;
`endif

    typedef struct {
        logic [63:0] imm64;
        logic [31:0] imm32;
        logic [4:0]  tag;
        logic        ill32;
        logic        ill64;
    } entry_t;

    entry_t mq[$];

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else             n_pass++;
    endtask

    // Architectural value of each format, from signed arithmetic on the instruction fields.
    function automatic logic [63:0] ref_imm(logic [31:0] i, logic [2:0] s, bit w64);
        longint v;
        case (s)
            3'd0:    v = longint'($signed(i[31:20]));
            3'd1:    v = longint'($signed({i[31:25], i[11:7]}));
            3'd2:    v = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
            3'd3:    v = longint'($signed(i[31:12])) * 4096;
            3'd4:    v = w64 ? longint'(i[25:20]) : longint'(i[24:20]);
            3'd5:    v = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
            3'd6:    v = longint'(i[19:15]);
            default: v = 0;
        endcase
        return v;
    endfunction

    function automatic entry_t mk(logic [31:0] i, logic [2:0] s, logic [4:0] t);
        entry_t e;
        logic [63:0] v32;
        v32     = ref_imm(i, s, 1'b0);
        e.imm32 = v32[31:0];
        e.imm64 = ref_imm(i, s, 1'b1);
        e.tag   = t;
`ifdef IMM_ILLEGAL_EN
        e.ill32 = (s == 3'd7) || (s == 3'd4 && i[25]);
        e.ill64 = (s == 3'd7);
`else
        e.ill32 = 1'b0;
        e.ill64 = 1'b0;
`endif
        return e;
    endfunction

    task automatic check_outs();
        chk("in_ready32",  in_ready32,  mq.size() < 2);
        chk("in_ready64",  in_ready64,  mq.size() < 2);
        chk("out_valid32", out_valid32, mq.size() > 0);
        chk("out_valid64", out_valid64, mq.size() > 0);
        if (mq.size() > 0) begin
            chk("imm32", out_imm32, mq[0].imm32);
            chk("imm64", out_imm64, mq[0].imm64);
            chk("tag32", out_tag32, mq[0].tag);
            chk("tag64", out_tag64, mq[0].tag);
            chk("ill32", ill32, mq[0].ill32);
            chk("ill64", ill64, mq[0].ill64);
        end
    endtask

    // Drives one cycle just after a falling edge, advances the model, checks at the next falling edge.
    task automatic step(bit v, logic [31:0] ins, logic [2:0] src, logic [4:0] tg, bit ordy, bit fl);
        bit acc, drn;
        in_valid  = v;
        instr     = ins;
        ImmSrc    = src;
        in_tag    = tg;
        out_ready = ordy;
        flush     = fl;
        acc = v && (mq.size() < 2) && !fl;
        drn = (mq.size() > 0) && ordy;
        if (fl) mq.delete();
        else begin
            if (drn) void'(mq.pop_front());
            if (acc) mq.push_back(mk(ins, src, tg));
        end
        @(negedge clk);
        check_outs();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = '0; ImmSrc = '0; in_tag = '0;
        @(negedge clk);
        chk("rst_valid", out_valid32, 1'b0);
        chk("rst_imm",   out_imm64,   64'h0);
        chk("rst_ready", in_ready32,  1'b1);
        rst = 1'b0;

        // I-type all-ones and J-type sign extension
        step(1, 32'hFFF00093, 3'd0, 5'd3, 1, 0);
        chk("t1_imm", out_imm32, 32'hFFFFFFFF);
        step(1, 32'h8000006F, 3'd5, 5'd4, 1, 0);
        chk("t2_imm", out_imm64, 64'hFFFFFFFFFFF00000);
        step(0, 32'h0, 3'd0, 5'd0, 1, 0);

        // Back-pressure fills both entries, then drains in order
        step(1, 32'h00500013, 3'd0, 5'd1, 0, 0);
        step(1, 32'h00600013, 3'd0, 5'd2, 0, 0);
        chk("t3_full", in_ready32, 1'b0);
        step(1, 32'h00700013, 3'd0, 5'd9, 1, 0);
        chk("t3_tag1", out_tag32, 5'd2);
        step(0, 32'h0, 3'd0, 5'd0, 1, 0);

        // Flush while full with a competing input
        step(1, 32'h12345678, 3'd3, 5'd5, 0, 0);
        step(1, 32'h87654321, 3'd1, 5'd6, 0, 0);
        step(1, 32'hFFFFFFFF, 3'd2, 5'd7, 0, 1);
        chk("t4_valid", out_valid32, 1'b0);
        chk("t4_ready", in_ready64, 1'b1);

        // Asynchronous reset while full
        step(1, 32'hABCDE000, 3'd3, 5'd8, 0, 0);
        step(1, 32'h80000000, 3'd3, 5'd9, 0, 0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t5_valid", out_valid64, 1'b0);
        chk("t5_imm",   out_imm64,   64'h0);
        chk("t5_tag",   out_tag32,   5'd0);
        mq.delete();
        @(negedge clk);
        rst = 1'b0;
        step(0, 32'h0, 3'd0, 5'd0, 1, 0);

`ifdef IMM_ILLEGAL_EN
        step(1, 32'hFFFFFFFF, 3'd7, 5'd10, 1, 0);
        chk("t6_imm7", out_imm32, 32'h0);
        chk("t6_ill7", ill32, 1'b1);
        step(1, 32'h000F8000, 3'd6, 5'd11, 1, 0);
        chk("t6_imm6", out_imm32, 32'd31);
        chk("t6_ill6", ill32, 1'b0);
        step(0, 32'h0, 3'd0, 5'd0, 1, 0);
`endif

        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 9) < 7, $urandom, 3'($urandom_range(0, 7)), 5'($urandom),
                 $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
